delay_and_sum: RTL and testbench
================================

DELAY_AND_SUM -- requirements
Module: delay_and_sum

Interface
REQ-001 Parameter DEPTH, default 64: frames held in the sample ring buffer; must be a power of two; maximum usable delay is DEPTH-1 frames.
REQ-002 Parameter SW, default 16: sample width in bits, signed two's complement.
REQ-003 i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_valid  input  1  i_sample is valid this cycle.
REQ-006 i_sample  input  SW  signed channel sample; channels arrive serially in order 0..15.
REQ-007 i_delta  input  16 x 8  unsigned per-channel delay in frames, indexed [15:0], each [7:0]; this is the delta vector from the delta generator.
REQ-008 o_ready  output  1  block accepts a sample this cycle.
REQ-009 o_sum  output  SW+4  signed delay-and-sum result.
REQ-010 o_valid  output  1  one-cycle pulse; o_sum is valid.

Function
REQ-011 A sample SHALL be accepted only on a cycle with i_valid=1 and o_ready=1; i_valid while o_ready=0 SHALL be ignored (the sample is dropped, not stalled).
REQ-012 The FSM SHALL have exactly three states: COLLECT, SUM, EMIT.
REQ-013 COLLECT: o_ready=1; the accepted sample SHALL be written to buffer[wr_frame][ch], and ch SHALL increment; after the sample with ch=15, the FSM SHALL enter SUM and ch SHALL wrap to 0.
REQ-014 When the channel-0 sample of a frame is accepted, all 16 i_delta values SHALL be latched; changes to i_delta during the rest of the frame SHALL have no effect on that frame.
REQ-015 Each latched delta greater than DEPTH-1 SHALL be saturated to DEPTH-1.
REQ-016 SUM: lasts exactly 16 cycles; in cycle k, channel k SHALL be read from frame (wr_frame - delta_k) mod DEPTH and added to an accumulator cleared at SUM entry; o_ready=0.
REQ-017 A read SHALL contribute 0 if delta_k >= frames_written, where frames_written counts completed frames including the current one and saturates at DEPTH; this prevents unwritten memory from entering the sum during warm-up.
REQ-018 The accumulator SHALL be SW+4 bits signed; 16 maximum-magnitude samples SHALL NOT overflow.
REQ-019 EMIT: lasts one cycle; o_valid=1 and o_sum is driven with the result; wr_frame SHALL increment modulo DEPTH, wrapping from DEPTH-1 to 0; the FSM SHALL then return to COLLECT.
REQ-020 Latency: o_valid SHALL assert exactly 17 cycles after the cycle that accepts channel 15.
REQ-021 o_sum SHALL hold its last value until the next EMIT.
REQ-022 Frame throughput SHALL be at most one frame per 33 cycles, with the source streaming back-to-back.

Reset
REQ-023 When i_rst=1 at a clock edge, the following values SHALL be set: state=COLLECT, ch=0, wr_frame=0, frames_written=0, accumulator=0, o_sum=0, o_valid=0, o_ready=1 from the next cycle.
REQ-024 Reset asserted during SUM or EMIT SHALL abort the frame with no o_valid pulse.
REQ-025 Buffer memory SHALL NOT be cleared by reset; REQ-017 masks stale contents.

Configuration
REQ-026 Macro DELAY_AND_SUM_AVG_EN.
  - Defined: o_sum SHALL be the accumulator arithmetically shifted right by 4, sign-extended to SW+4 bits (the channel mean).
  - Undefined: o_sum SHALL be the full accumulator sum.
  - Timing and handshake SHALL be identical in both builds.

Verification
REQ-027 Reset, all deltas 0, one frame with every channel sample = 100 -> o_valid pulse 17 cycles after channel 15; o_sum=1600 (AVG_EN: 100).
REQ-028 Frames f=0..3 with all samples = f+1, delta_k=k mod 4 -> frame-3 o_sum = 4*(4+3+2+1) = 40.
REQ-029 Frame 0 only, samples = -5, delta_k=k -> only channel 0 contributes; o_sum=-5 (AVG_EN: -1).
REQ-030 After 70 frames, delta_0=200 -> delta saturates to 63; channel 0 reads the frame 63 back, and the read address wraps correctly across wr_frame=0.
REQ-031 i_valid held high through SUM/EMIT -> those samples are not written, and the next frame starts at ch=0 on return to COLLECT.
REQ-032 i_rst pulsed at SUM cycle 8 -> no o_valid, o_sum=0; the next frame behaves as the first frame after reset.

Source files
------------

// File: rtl/delay_and_sum.sv
// delay_and_sum: 16-channel delay-and-sum beamformer.
// Samples arrive serially (channels 0..15) into a DEPTH-frame ring buffer.
// A 16-cycle SUM pass reads each channel from its delayed frame, and a
// one-cycle EMIT pulses o_valid with the result.
// Optional build macro: DELAY_AND_SUM_AVG_EN -- when defined, o_sum is the
// channel mean (accumulator >>> 4) instead of the full sum.
module delay_and_sum #(
  parameter int DEPTH = 64,
  parameter int SW    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic signed [SW-1:0] i_sample,
  input  logic [15:0][7:0]     i_delta,
  output logic                 o_ready,
  output logic signed [SW+3:0] o_sum,
  output logic                 o_valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = AW + 1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SUM     = 2'd1,
    EMIT    = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             ch_q, ch_d;
  logic [AW-1:0]          wr_frame_q, wr_frame_d;
  logic [FW-1:0]          frames_written_q, frames_written_d;
  logic signed [SW+3:0]   acc_q, acc_d;
  logic [15:0][AW-1:0]    delta_q, delta_d;
  logic signed [SW+3:0]   o_sum_q, o_sum_d;
  logic                   o_valid_q, o_valid_d;

  // Ring buffer, addressed as {frame, channel}; deliberately not reset.
  logic signed [SW-1:0]   mem [DEPTH*16];

  logic                   wr_en_s;
  logic [AW-1:0]          rd_frame_s;
  logic signed [SW-1:0]   rd_data_s;
  logic                   rd_masked_s;
  logic signed [SW+3:0]   term_s;
  logic signed [SW+3:0]   acc_next_s;

  // Clamp a raw 8-bit delta to the largest delay the buffer can hold.
  function automatic logic [AW-1:0] sat_delta(input logic [7:0] d);
    logic [31:0] d32;
    d32 = {24'd0, d};
    if (d32 > 32'(DEPTH - 1)) begin
      return AW'(DEPTH - 1);
    end else begin
      return d32[AW-1:0];
    end
  endfunction

  assign wr_en_s = i_valid && (state_q == COLLECT);

  // During SUM, ch_q doubles as the channel index k being read.
  assign rd_frame_s  = wr_frame_q - delta_q[ch_q];
  assign rd_data_s   = mem[{rd_frame_s, ch_q}];
  // Frames not yet written since reset must not contribute.
  assign rd_masked_s = ({{(FW-AW){1'b0}}, delta_q[ch_q]} >= frames_written_q);
  assign term_s      = rd_masked_s ? '0 : {{4{rd_data_s[SW-1]}}, rd_data_s};
  assign acc_next_s  = acc_q + term_s;

  // Write accepted samples into the current frame slot.
  always_ff @(posedge i_clk) begin
    if (wr_en_s) begin
      mem[{wr_frame_q, ch_q}] <= i_sample;
    end
  end

  // Next-state and datapath update for the COLLECT/SUM/EMIT sequencer.
  always_comb begin
    state_d          = state_q;
    ch_d             = ch_q;
    wr_frame_d       = wr_frame_q;
    frames_written_d = frames_written_q;
    acc_d            = acc_q;
    delta_d          = delta_q;
    o_sum_d          = o_sum_q;
    o_valid_d        = 1'b0;
    case (state_q)
      COLLECT: begin
        if (i_valid) begin
          ch_d = ch_q + 4'd1;
          if (ch_q == 4'd0) begin
            for (int k = 0; k < 16; k++) begin
              delta_d[k] = sat_delta(i_delta[k]);
            end
          end else begin
            delta_d = delta_q;
          end
          if (ch_q == 4'd15) begin
            state_d = SUM;
            acc_d   = '0;
            if (frames_written_q != FW'(DEPTH)) begin
              frames_written_d = frames_written_q + FW'(1);
            end else begin
              frames_written_d = frames_written_q;
            end
          end else begin
            state_d = COLLECT;
          end
        end else begin
          ch_d = ch_q;
        end
      end
      SUM: begin
        acc_d = acc_next_s;
        ch_d  = ch_q + 4'd1;
        if (ch_q == 4'd15) begin
          state_d   = EMIT;
          o_valid_d = 1'b1;
`ifdef DELAY_AND_SUM_AVG_EN
          o_sum_d   = acc_next_s >>> 4;
`else
          o_sum_d   = acc_next_s;
`endif
        end else begin
          state_d = SUM;
        end
      end
      EMIT: begin
        wr_frame_d = wr_frame_q + AW'(1);
        state_d    = COLLECT;
      end
      default: begin
        state_d = COLLECT;
        ch_d    = 4'd0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= COLLECT;
      ch_q             <= 4'd0;
      wr_frame_q       <= '0;
      frames_written_q <= '0;
      acc_q            <= '0;
      delta_q          <= '0;
      o_sum_q          <= '0;
      o_valid_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      ch_q             <= ch_d;
      wr_frame_q       <= wr_frame_d;
      frames_written_q <= frames_written_d;
      acc_q            <= acc_d;
      delta_q          <= delta_d;
      o_sum_q          <= o_sum_d;
      o_valid_q        <= o_valid_d;
    end
  end

  assign o_ready = (state_q == COLLECT);
  assign o_sum   = o_sum_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_delay_and_sum.sv
// Self-checking bench for delay_and_sum with a frame-history reference model.
module tb_delay_and_sum;

  localparam int DEPTH = 64;
  localparam int SW    = 16;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_valid;
  logic signed [SW-1:0] i_sample;
  logic [15:0][7:0]     i_delta;
  logic                 o_ready;
  logic signed [SW+3:0] o_sum;
  logic                 o_valid;

  int checks = 0;
  int errors = 0;

  // Stimulus for the next frame and the history of all frames since reset.
  int smp [16];
  int dly [16];
  int hist [256][16];
  int nf;
  logic signed [SW+3:0] last_sum;

  delay_and_sum #(.DEPTH(DEPTH), .SW(SW)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .i_sample (i_sample),
    .i_delta  (i_delta),
    .o_ready  (o_ready),
    .o_sum    (o_sum),
    .o_valid  (o_valid)
  );

  always #5 i_clk = ~i_clk;

  // Reference: frame nf reads channel k from frame nf-min(d,DEPTH-1) if already written.
  function automatic int model_sum();
    int acc;
    int de;
    int fw;
    acc = 0;
    fw = (nf + 1 < DEPTH) ? nf + 1 : DEPTH;
    for (int k = 0; k < 16; k++) begin
      de = (dly[k] > DEPTH - 1) ? DEPTH - 1 : dly[k];
      if (de < fw) acc += hist[nf - de][k];
    end
`ifdef DELAY_AND_SUM_AVG_EN
    acc = acc >>> 4;
`endif
    return acc;
  endfunction

  task automatic do_reset();
    i_rst   = 1'b1;
    i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst   = 1'b0;
    nf      = 0;
    last_sum = '0;
  endtask

  // Drive one frame of 16 samples, then measure latency and result.
  task automatic run_frame(input bit stream_valid, input bit gaps, input string tag);
    int exp_i;
    int lat;
    bit ready_bad;
    logic signed [SW+3:0] got;
    logic signed [SW+3:0] exp_v;
    for (int k = 0; k < 16; k++) hist[nf][k] = smp[k];
    exp_i = model_sum();
    exp_v = (SW+4)'(exp_i);
    for (int k = 0; k < 16; k++) i_delta[k] = 8'(dly[k]);
    for (int k = 0; k < 16; k++) begin
      if (gaps && $urandom_range(3) == 0) begin
        i_valid  = 1'b0;
        i_sample = SW'($urandom);
        @(posedge i_clk); #1;
      end
      i_valid  = 1'b1;
      i_sample = SW'(smp[k]);
      @(posedge i_clk); #1;
      // Deltas must be frozen after channel 0; scramble them.
      for (int j = 0; j < 16; j++) i_delta[j] = 8'($urandom);
    end
    i_valid  = stream_valid;
    i_sample = SW'(16'sd999);
    lat = -1;
    got = 'x;
    ready_bad = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (o_valid === 1'b1) begin
        lat = n;
        got = o_sum;
        break;
      end
      if (o_ready !== 1'b0) ready_bad = 1'b1;
      i_sample = SW'($urandom);
      @(posedge i_clk); #1;
    end
    checks++;
    if (lat != 17) begin
      errors++;
      $display("FAIL %s latency: got %0d expected 17", tag, lat);
    end
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s sum: got %0d expected %0d", tag, got, exp_v);
    end
    checks++;
    if (ready_bad) begin
      errors++;
      $display("FAIL %s ready_in_sum: got 1 expected 0", tag);
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_sum !== exp_v || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s hold: valid=%b sum=%0d ready=%b expected 0/%0d/1",
               tag, o_valid, o_sum, o_ready, exp_v);
    end
    last_sum = exp_v;
    nf++;
  endtask

  task automatic test_reset();
    i_sample = '0;
    i_delta  = '0;
    do_reset();
    checks++;
    if (o_valid !== 1'b0 || o_sum !== '0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b sum=%0d ready=%b expected 0/0/1", o_valid, o_sum, o_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int k = 0; k < 16; k++) begin smp[k] = 100; dly[k] = 0; end
    run_frame(1'b0, 1'b0, "basic");
  endtask

  task automatic test_warmup();
    do_reset();
    for (int k = 0; k < 16; k++) begin smp[k] = -5; dly[k] = k; end
    run_frame(1'b0, 1'b0, "warmup");
  endtask

  task automatic test_history();
    do_reset();
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 16; k++) begin smp[k] = f + 1; dly[k] = k % 4; end
      run_frame(1'b0, 1'b0, "history");
    end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int k = 0; k < 16; k++) begin smp[k] = -32768; dly[k] = 0; end
    run_frame(1'b0, 1'b0, "min_neg");
    for (int k = 0; k < 16; k++) begin smp[k] = 32767; dly[k] = 0; end
    run_frame(1'b0, 1'b0, "max_pos");
  endtask

  task automatic test_random_wrap();
    do_reset();
    for (int f = 0; f < 70; f++) begin
      for (int k = 0; k < 16; k++) begin
        smp[k] = int'($urandom_range(65535)) - 32768;
        dly[k] = ($urandom_range(1) == 0) ? int'($urandom_range(DEPTH - 1)) : int'($urandom_range(255));
      end
      run_frame(1'($urandom_range(1)), 1'($urandom_range(1)), "random");
    end
    for (int k = 0; k < 16; k++) begin
      smp[k] = int'($urandom_range(65535)) - 32768;
      dly[k] = int'($urandom_range(DEPTH - 1));
    end
    dly[0] = 200;
    run_frame(1'b0, 1'b0, "sat_wrap");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 16; k++) begin smp[k] = 10 * f + k; dly[k] = f; end
      run_frame(1'b1, 1'b0, "back_to_back");
    end
  endtask

  task automatic test_abort();
    bit seen;
    do_reset();
    for (int k = 0; k < 16; k++) begin smp[k] = 7; dly[k] = 0; end
    run_frame(1'b0, 1'b0, "pre_abort");
    for (int k = 0; k < 16; k++) begin
      i_valid  = 1'b1;
      i_sample = SW'(16'sd300);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    repeat (8) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (o_valid !== 1'b0) seen = 1'b1;
      @(posedge i_clk); #1;
    end
    checks++;
    if (seen || o_sum !== '0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort: pulse=%b sum=%0d ready=%b expected 0/0/1", seen, o_sum, o_ready);
    end
    nf = 0;
    for (int k = 0; k < 16; k++) begin smp[k] = -5; dly[k] = k; end
    run_frame(1'b0, 1'b0, "post_abort");
  endtask

  initial begin
    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_sample = '0;
    i_delta  = '0;
    nf       = 0;
    test_reset();
    test_basic();
    test_warmup();
    test_history();
    test_extremes();
    test_back_to_back();
    test_random_wrap();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
